// File: rtl/bfp_piso_out.sv
// Converts one block-floating-point group (four signed mantissas, one shared exponent)
// to FP16 and streams the four results out serially. Define BFP_PISO_SAT_EN to saturate on overflow.
module bfp_piso_out #(
    parameter int mantissa_size = 10,
    parameter int exponent_size = 5,
    parameter int output_size   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [4*(mantissa_size+1)-1:0]     m_in,
    input  logic [exponent_size-1:0]           exp_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [output_size-1:0]             out_data,
    output logic                               out_last
);

    localparam int mw      = mantissa_size + 1;
    localparam int exp_max = (1 << exponent_size) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                   state_reg;
    logic [1:0]               idx_reg;
    logic [4*mw-1:0]          m_reg;
    logic [exponent_size-1:0] exp_reg;
    logic [output_size-1:0]   out_buf_reg [4];
    logic [output_size-1:0]   conv [4];

    // A mantissa of 512 (leading one at bit mantissa_size-1) represents 1.0 at the shared
    // exponent, so the FP16 exponent is E + p - (mantissa_size-1). The shift is exact.
    function automatic logic [output_size-1:0] to_fp16(
        input logic [mw-1:0]            m,
        input logic [exponent_size-1:0] e_in
    );
        logic                     s;
        logic [mw-1:0]            a;
        logic [3:0]               p;
        logic [3:0]               shamt;
        logic [mantissa_size-1:0] frac;
        int                       e;
        logic [output_size-1:0]   r;

        s = m[mw-1];
        a = s ? (~m + 1'b1) : m;
        p = '0;
        for (int i = 0; i < mw; i++) begin
            if (a[i]) begin
                p = 4'(i);
            end
        end
        shamt = 4'(mantissa_size) - p;
        frac  = mantissa_size'(a << shamt);
        e     = int'(e_in) + int'(p) - (mantissa_size - 1);

        if (a == '0) begin
            r = '0;
        end else if (int'(e_in) == exp_max) begin
            r = {1'b0, {exponent_size{1'b1}}, 1'b1, {(mantissa_size-1){1'b0}}};
        end else if (e <= 0) begin
            r = {s, {(output_size-1){1'b0}}};
        end else if (e >= exp_max) begin
`ifdef BFP_PISO_SAT_EN
            r = {s, {(exponent_size-1){1'b1}}, 1'b0, {mantissa_size{1'b1}}};
`else
            r = {s, {exponent_size{1'b1}}, {mantissa_size{1'b0}}};
`endif
        end else begin
            r = {s, exponent_size'(e), frac};
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_conv
            assign conv[gi] = to_fp16(m_reg[gi*mw +: mw], exp_reg);
        end
    endgenerate

    // The last accepted beat frees the block, letting the next group in without an IDLE cycle.
    assign in_ready = !rst && ((state_reg == IDLE) ||
                               (state_reg == SEND && idx_reg == 2'd3 && out_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            m_reg     <= '0;
            exp_reg   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            for (int k = 0; k < 4; k++) begin
                out_buf_reg[k] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        m_reg     <= m_in;
                        exp_reg   <= exp_in;
                        state_reg <= CONV;
                    end
                end
                CONV: begin
                    for (int k = 0; k < 4; k++) begin
                        out_buf_reg[k] <= conv[k];
                    end
                    out_data  <= conv[0];
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    idx_reg   <= '0;
                    state_reg <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx_reg == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            idx_reg   <= '0;
                            if (in_valid) begin
                                m_reg     <= m_in;
                                exp_reg   <= exp_in;
                                state_reg <= CONV;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            idx_reg  <= idx_reg + 2'd1;
                            out_data <= out_buf_reg[idx_reg + 2'd1];
                            out_last <= (idx_reg == 2'd2);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bfp_piso_out.sv
// Directed self-checking bench for bfp_piso_out: conversion vectors, latency, backpressure,
// back-to-back groups and mid-group reset.
module tb_bfp_piso_out;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [43:0] m_in;
    logic [4:0]  exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    int checks = 0;
    int errors = 0;

`ifdef BFP_PISO_SAT_EN
    localparam logic [15:0] ovf_neg = 16'hFBFF;
`else
    localparam logic [15:0] ovf_neg = 16'hFC00;
`endif

    bfp_piso_out dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m_in      (m_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [43:0] pack4(input int a, input int b, input int c, input int d);
        return {d[10:0], c[10:0], b[10:0], a[10:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; m_in = '0; exp_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data got %h want 0000", out_data); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
        checks++;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
        checks++;
        $display("reset sequence done");
    endtask

    task automatic test_basic();
        logic [15:0] exp_d [4] = '{16'h3C00, 16'hBC00, 16'h0000, 16'h3DFE};
        @(posedge clk); #1;
        m_in = pack4(512, -512, 0, 767); exp_in = 5'd15; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
        checks++;
        @(posedge clk); #1;
        in_valid = 1'b0; m_in = pack4(-1, -1, -1, -1); exp_in = 5'd31;
        @(negedge clk);
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_conv_valid got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_conv_in_ready got %b want 0", in_ready); end
        checks++;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %b want 1", k, out_valid); end
            checks++;
            if (out_data !== exp_d[k]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", k, out_data, exp_d[k]); end
            checks++;
            if (out_last !== (k == 3)) begin errors++; $display("FAIL basic_last[%0d] got %b want %b", k, out_last, (k == 3)); end
            checks++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_end_valid got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_end_in_ready got %b want 1", in_ready); end
        checks++;
        $display("group basic done");
    endtask

    task automatic test_conversion();
        logic [43:0] vm [4];
        logic [4:0]  ve [4];
        logic [15:0] vx [4][4];
        vm[0] = pack4(1, -1, 0, 0);        ve[0] = 5'd15; vx[0] = '{16'h1800, 16'h9800, 16'h0000, 16'h0000};
        vm[1] = pack4(1, -1, 2, 512);      ve[1] = 5'd1;  vx[1] = '{16'h0000, 16'h8000, 16'h0000, 16'h0400};
        vm[2] = pack4(-1024, 1023, 0, 0);  ve[2] = 5'd30; vx[2] = '{ovf_neg, 16'h7BFE, 16'h0000, 16'h0000};
        vm[3] = pack4(5, 0, 0, 0);         ve[3] = 5'd31; vx[3] = '{16'h7E00, 16'h0000, 16'h0000, 16'h0000};
        for (int g = 0; g < 4; g++) begin
            @(posedge clk); #1;
            m_in = vm[g]; exp_in = ve[g]; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (out_valid !== 1'b1 || out_data !== vx[g][k]) begin
                    errors++;
                    $display("FAIL conv_data[%0d][%0d] got %h (valid %b) want %h", g, k, out_data, out_valid, vx[g][k]);
                end
                checks++;
                if (out_last !== (k == 3)) begin errors++; $display("FAIL conv_last[%0d][%0d] got %b want %b", g, k, out_last, (k == 3)); end
                checks++;
            end
            @(posedge clk); #1;
            $display("group conversion %0d done", g);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_d [4] = '{16'h3C00, 16'h3800, 16'h3400, 16'h3000};
        @(posedge clk); #1;
        m_in = pack4(512, 256, 128, 64); exp_in = 5'd15; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        if (out_data !== exp_d[0]) begin errors++; $display("FAIL bp_data[0] got %h want %h", out_data, exp_d[0]); end
        checks++;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== exp_d[1]) begin
                errors++;
                $display("FAIL bp_hold[%0d] got %h (valid %b) want %h", i, out_data, out_valid, exp_d[1]);
            end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
            checks++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== exp_d[k]) begin
                errors++;
                $display("FAIL bp_data[%0d] got %h (valid %b) want %h", k, out_data, out_valid, exp_d[k]);
            end
            checks++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %b want 0", out_valid); end
        checks++;
        $display("group backpressure done");
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_a [4] = '{16'h3C00, 16'hBC00, 16'h3800, 16'hB800};
        logic [15:0] exp_b [4] = '{16'h1800, 16'h1C00, 16'h2000, 16'h2400};
        @(posedge clk); #1;
        m_in = pack4(512, -512, 256, -256); exp_in = 5'd15; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                m_in = pack4(1, 2, 4, 8); exp_in = 5'd15; in_valid = 1'b1;
            end
            @(negedge clk);
            if (out_data !== exp_a[k]) begin errors++; $display("FAIL b2b_a_data[%0d] got %h want %h", k, out_data, exp_a[k]); end
            checks++;
            if (k == 3) begin
                if (in_ready !== 1'b1 || out_last !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_handover got in_ready %b last %b want 1 1", in_ready, out_last);
                end
                checks++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_conv got valid %b in_ready %b want 0 0", out_valid, in_ready);
        end
        checks++;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== exp_b[k]) begin
                errors++;
                $display("FAIL b2b_b_data[%0d] got %h (valid %b) want %h", k, out_data, out_valid, exp_b[k]);
            end
            checks++;
        end
        @(posedge clk); #1;
        $display("group back_to_back done");
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_n [4] = '{16'h3000, 16'h3400, 16'h3800, 16'h3C00};
        @(posedge clk); #1;
        m_in = pack4(512, 256, 128, 64); exp_in = 5'd15; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        if (out_data !== 16'h3400 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_before got data %h in_ready %b want 3400 0", out_data, in_ready);
        end
        checks++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL rmid_after got valid %b last %b want 0 0", out_valid, out_last);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        checks++;
        @(posedge clk); #1;
        m_in = pack4(64, 128, 256, 512); exp_in = 5'd15; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== exp_n[k]) begin
                errors++;
                $display("FAIL rmid_data[%0d] got %h (valid %b) want %h", k, out_data, out_valid, exp_n[k]);
            end
            checks++;
        end
        @(posedge clk); #1;
        $display("group reset_mid done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_conversion();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
